// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
// Includes FSM states, PC-select encodings and the control bundle driven each cycle.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned PC_SEL_W = 2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    EXC      = 2'd2
  } state_e;

  localparam logic [PC_SEL_W-1:0] PC_SEL_SEQ    = 2'd0;
  localparam logic [PC_SEL_W-1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [PC_SEL_W-1:0] PC_SEL_JUMP   = 2'd2;
  localparam logic [PC_SEL_W-1:0] PC_SEL_EXC    = 2'd3;

  localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

  typedef struct packed {
    logic                pc_write;
    logic [PC_SEL_W-1:0] pc_sel;
    logic                if_id_write;
    logic                if_id_flush;
    logic                id_ex_write;
    logic                id_ex_flush;
    logic                ex_mem_write;
    logic                mem_wb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = '{
    pc_write: 1'b1, pc_sel: PC_SEL_SEQ, if_id_write: 1'b1, if_id_flush: 1'b0,
    id_ex_write: 1'b1, id_ex_flush: 1'b0, ex_mem_write: 1'b1, mem_wb_flush: 1'b0
  };

  localparam ctrl_t CTRL_FREEZE = '{
    pc_write: 1'b0, pc_sel: PC_SEL_SEQ, if_id_write: 1'b0, if_id_flush: 1'b0,
    id_ex_write: 1'b0, id_ex_flush: 1'b0, ex_mem_write: 1'b0, mem_wb_flush: 1'b1
  };

  localparam ctrl_t CTRL_EXC = '{
    pc_write: 1'b1, pc_sel: PC_SEL_EXC, if_id_write: 1'b1, if_id_flush: 1'b1,
    id_ex_write: 1'b1, id_ex_flush: 1'b1, ex_mem_write: 1'b1, mem_wb_flush: 1'b1
  };

  // Normal-flow resolution: branch beats jump beats load-use.
  function automatic ctrl_t resolve_ctrl(input logic branch, input logic jump, input logic lu);
    ctrl_t c;
    c = CTRL_RUN;
    if (branch) begin
      c.pc_sel      = PC_SEL_BRANCH;
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (jump) begin
      c.pc_sel      = PC_SEL_JUMP;
      c.if_id_flush = 1'b1;
    end else if (lu) begin
      c.pc_write    = 1'b0;
      c.if_id_write = 1'b0;
      c.id_ex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_rt,
  output logic             lu_hazard
);

  // r0 is hardwired, so a load targeting it never creates a dependency.
  assign lu_hazard = id_ex_mem_read && (id_ex_rt != REG_W'(0)) &&
                     ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: stall, flush and PC select for the 5-stage pipeline,
// with a data-memory timeout watchdog and stall/flush performance counters.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_W-1:0]    if_id_rs,
  input  logic [REG_W-1:0]    if_id_rt,
  input  logic                if_id_uses_rt,
  input  logic                id_ex_mem_read,
  input  logic [REG_W-1:0]    id_ex_rt,
  input  logic                jump_id,
  input  logic                branch_taken_ex,
  input  logic                mem_req,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic [PC_SEL_W-1:0] pc_sel,
  output logic                if_id_write,
  output logic                if_id_flush,
  output logic                id_ex_write,
  output logic                id_ex_flush,
  output logic                ex_mem_write,
  output logic                mem_wb_flush,
  output logic                bus_error,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e              state, state_next;
  logic [WAIT_W-1:0]   wait_cnt, wait_next;
  logic                berr_set;
  logic                lu_hazard;
  ctrl_t               ctrl, ctrl_out;

  load_use_detect u_load_use_detect (
    .if_id_rs       (if_id_rs),
    .if_id_rt       (if_id_rt),
    .if_id_uses_rt  (if_id_uses_rt),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rt       (id_ex_rt),
    .lu_hazard      (lu_hazard)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // wait_cnt holds the number of freeze cycles already completed; the cycle that
  // first sees the miss in RUN is itself a freeze cycle, so entry loads 1.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    berr_set   = 1'b0;
    ctrl       = CTRL_RUN;
    unique case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          ctrl      = CTRL_FREEZE;
          wait_next = WAIT_W'(1);
          if (MEM_TIMEOUT <= 1) begin
            state_next = EXC;
            berr_set   = 1'b1;
          end else begin
            state_next = MEM_WAIT;
          end
        end else begin
          ctrl = resolve_ctrl(branch_taken_ex, jump_id, lu_hazard);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          ctrl       = resolve_ctrl(branch_taken_ex, jump_id, lu_hazard);
          state_next = RUN;
        end else begin
          ctrl      = CTRL_FREEZE;
          wait_next = wait_cnt + WAIT_W'(1);
          if (32'(wait_cnt) + 32'd1 >= MEM_TIMEOUT) begin
            state_next = EXC;
            berr_set   = 1'b1;
          end
        end
      end
      EXC: begin
        ctrl       = CTRL_EXC;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // Watchdog, sticky error and performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt  <= '0;
      bus_error <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      wait_cnt  <= wait_next;
      bus_error <= bus_error | berr_set;
      if (!ctrl.pc_write)   stall_cnt <= stall_cnt + CNT_W'(1);
      if (ctrl.if_id_flush) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // Reset forces the free-running pipeline controls regardless of inputs.
  assign ctrl_out     = reset ? CTRL_RUN : ctrl;
  assign pc_write     = ctrl_out.pc_write;
  assign pc_sel       = ctrl_out.pc_sel;
  assign if_id_write  = ctrl_out.if_id_write;
  assign if_id_flush  = ctrl_out.if_id_flush;
  assign id_ex_write  = ctrl_out.id_ex_write;
  assign id_ex_flush  = ctrl_out.id_ex_flush;
  assign ex_mem_write = ctrl_out.ex_mem_write;
  assign mem_wb_flush = ctrl_out.mem_wb_flush;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a short watchdog and 4-bit counters.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TMO  = 4;
  localparam int unsigned CW   = 4;

  // {pc_write, pc_sel[1:0], if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush}
  localparam logic [8:0] EXP_NORM = 9'b1_00_1_0_1_0_1_0;
  localparam logic [8:0] EXP_LU   = 9'b0_00_0_0_1_1_1_0;
  localparam logic [8:0] EXP_BR   = 9'b1_01_1_1_1_1_1_0;
  localparam logic [8:0] EXP_JMP  = 9'b1_10_1_1_1_0_1_0;
  localparam logic [8:0] EXP_FRZ  = 9'b0_00_0_0_0_0_0_1;
  localparam logic [8:0] EXP_EXC  = 9'b1_11_1_1_1_1_1_1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    if_id_rs, if_id_rt, id_ex_rt;
  logic          if_id_uses_rt, id_ex_mem_read, jump_id, branch_taken_ex, mem_req, mem_ready;
  logic          pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write;
  logic          mem_wb_flush, bus_error;
  logic [1:0]    pc_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [8:0]    ctrl_obs;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .jump_id(jump_id), .branch_taken_ex(branch_taken_ex),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_sel(pc_sel),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
    .ex_mem_write(ex_mem_write), .mem_wb_flush(mem_wb_flush),
    .bus_error(bus_error), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  assign ctrl_obs = {pc_write, pc_sel, if_id_write, if_id_flush, id_ex_write,
                     id_ex_flush, ex_mem_write, mem_wb_flush};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_id_rs = 5'd0; if_id_rt = 5'd0; if_id_uses_rt = 1'b0;
    id_ex_mem_read = 1'b0; id_ex_rt = 5'd0;
    jump_id = 1'b0; branch_taken_ex = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_lu();
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    set_lu();
    branch_taken_ex = 1'b1;
    #12;
    check("reset_ctrl", 32'(ctrl_obs), 32'(EXP_NORM));
    check("reset_stall", 32'(stall_cnt), 0);
    check("reset_flush", 32'(flush_cnt), 0);
    check("reset_berr", 32'(bus_error), 0);
    clear_inputs();
    cyc();
    reset = 1'b0;
    #1;
    check("idle_ctrl", 32'(ctrl_obs), 32'(EXP_NORM));

    // load-use on rs, exactly one bubble
    set_lu(); #1;
    check("lu_rs_ctrl", 32'(ctrl_obs), 32'(EXP_LU));
    cyc();
    id_ex_mem_read = 1'b0; #1;
    check("lu_after_ctrl", 32'(ctrl_obs), 32'(EXP_NORM));
    check("lu_stall1", 32'(stall_cnt), 1);
    cyc();
    // load-use on rt, then rt unused, then r0 target
    clear_inputs();
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd3; if_id_rt = 5'd8; if_id_uses_rt = 1'b1; #1;
    check("lu_rt_ctrl", 32'(ctrl_obs), 32'(EXP_LU));
    cyc();
    if_id_uses_rt = 1'b0; #1;
    check("lu_rt_unused", 32'(ctrl_obs), 32'(EXP_NORM));
    cyc();
    id_ex_rt = 5'd0; if_id_rs = 5'd0; if_id_rt = 5'd0; if_id_uses_rt = 1'b1; #1;
    check("lu_r0_ctrl", 32'(ctrl_obs), 32'(EXP_NORM));
    cyc();
    check("lu_stall2", 32'(stall_cnt), 2);

    // branch + jump + load-use: branch wins with no stall
    clear_inputs();
    set_lu(); jump_id = 1'b1; branch_taken_ex = 1'b1; #1;
    check("br_prio_ctrl", 32'(ctrl_obs), 32'(EXP_BR));
    cyc();
    check("br_flush1", 32'(flush_cnt), 1);
    check("br_nostall", 32'(stall_cnt), 2);
    branch_taken_ex = 1'b0; id_ex_mem_read = 1'b0; #1;
    check("jmp_ctrl", 32'(ctrl_obs), 32'(EXP_JMP));
    cyc();
    set_lu(); #1;
    check("jmp_over_lu", 32'(ctrl_obs), 32'(EXP_JMP));
    cyc();
    check("jmp_flush3", 32'(flush_cnt), 3);
    check("jmp_nostall", 32'(stall_cnt), 2);

    // 3-cycle memory wait with a branch held; branch applied on release
    clear_inputs();
    mem_req = 1'b1; branch_taken_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("frz%0d_ctrl", i), 32'(ctrl_obs), 32'(EXP_FRZ));
      cyc();
    end
    check("frz_stall5", 32'(stall_cnt), 5);
    check("frz_flush3", 32'(flush_cnt), 3);
    mem_ready = 1'b1; #1;
    check("release_ctrl", 32'(ctrl_obs), 32'(EXP_BR));
    cyc();
    check("release_flush4", 32'(flush_cnt), 4);
    branch_taken_ex = 1'b0; #1;
    check("hit_ctrl", 32'(ctrl_obs), 32'(EXP_NORM));
    cyc();
    check("hit_nostall", 32'(stall_cnt), 5);

    // watchdog timeout
    clear_inputs();
    do_reset();
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("tmo%0d_ctrl", i), 32'(ctrl_obs), 32'(EXP_FRZ));
      cyc();
      check($sformatf("tmo%0d_berr", i), 32'(bus_error), (i == 3) ? 1 : 0);
    end
    mem_req = 1'b0; #1;
    check("exc_ctrl", 32'(ctrl_obs), 32'(EXP_EXC));
    cyc();
    check("post_exc_ctrl", 32'(ctrl_obs), 32'(EXP_NORM));
    check("post_exc_berr", 32'(bus_error), 1);
    check("tmo_stall4", 32'(stall_cnt), 4);
    check("tmo_flush1", 32'(flush_cnt), 1);
    cyc();
    check("berr_sticky", 32'(bus_error), 1);

    // asynchronous reset in the middle of a wait
    mem_req = 1'b1;
    cyc(); cyc();
    #2;
    reset = 1'b1;
    #1;
    check("rst_mw_ctrl", 32'(ctrl_obs), 32'(EXP_NORM));
    check("rst_mw_stall", 32'(stall_cnt), 0);
    check("rst_mw_flush", 32'(flush_cnt), 0);
    check("rst_mw_berr", 32'(bus_error), 0);
    cyc();
    reset = 1'b0; mem_req = 1'b0; #1;
    check("rst_mw_run", 32'(ctrl_obs), 32'(EXP_NORM));

    // 17 stalls wrap a 4-bit counter to 1
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_lu(); #1;
      cyc();
      id_ex_mem_read = 1'b0;
      cyc();
    end
    check("stall_wrap", 32'(stall_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and sequencing controller for the 5-stage pipeline. It drives the hold and flush controls of the IF/ID, ID/EX and EX/MEM registers and the PC next-address select. It resolves load-use stalls, ID-stage jumps, EX-stage taken branches and data-memory wait states. It also runs a memory-timeout watchdog that redirects to the exception vector, and keeps stall and flush performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum consecutive wait cycles before a bus error is raised.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- if_id_rs  in  5  rs field of the instruction in ID.
- if_id_rt  in  5  rt field of the instruction in ID.
- if_id_uses_rt  in  1  ID instruction reads rt.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_rt  in  5  destination register of the load in EX.
- jump_id  in  1  J/JAL/JR decoded in ID.
- branch_taken_ex  in  1  branch resolved taken in EX.
- mem_req  in  1  MEM stage holds a valid load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC register update enable.
- pc_sel  out  2  next-PC select: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = exception vector.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID clear.
- id_ex_write  out  1  ID/EX load enable.
- id_ex_flush  out  1  ID/EX clear (bubble).
- ex_mem_write  out  1  EX/MEM load enable.
- mem_wb_flush  out  1  insert a bubble into MEM/WB.
- bus_error  out  1  sticky flag for a memory timeout.
- stall_cnt  out  CNT_W  cycles with pc_write = 0.
- flush_cnt  out  CNT_W  cycles with if_id_flush = 1.

## Operation
FSM states: RUN, MEM_WAIT, EXC.

- **RUN**
  - Go to MEM_WAIT if mem_req && !mem_ready.
  - Otherwise resolve this cycle by strict priority:
    1. branch_taken_ex: pc_sel = 1, if_id_flush = 1, id_ex_flush = 1.
    2. jump_id: pc_sel = 2, if_id_flush = 1.
    3. Load-use: pc_write = 0, if_id_write = 0, id_ex_flush = 1.
    4. Default: all write enables = 1, all flushes = 0, pc_sel = 0.
  - Load-use condition: id_ex_mem_read && id_ex_rt != 0 && (id_ex_rt == if_id_rs || (if_id_uses_rt && id_ex_rt == if_id_rt)).
- **MEM_WAIT** (freeze)
  - Outputs: pc_write = if_id_write = id_ex_write = ex_mem_write = 0, mem_mw flush = 0 on IF/ID and ID/EX, mem_wb_flush = 1.
  - The wait counter increments every cycle.
  - mem_ready = 1: go to RUN. In this same cycle, outputs are the normal RUN resolution, but the mem_req wait check is ignored.
  - Wait counter reaches MEM_TIMEOUT with mem_ready = 0: go to EXC and set bus_error.
  - Branch or jump inputs held during the freeze are applied only on the release cycle.
- **EXC** (one cycle)
  - Outputs: pc_sel = 3, pc_write = 1, if_id_flush = 1, id_ex_flush = 1, mem_wb_flush = 1, ex_mem_write = 1.
  - Next state is RUN.
- bus_error clears only on reset.
- The wait counter clears on every entry to MEM_WAIT.
- stall_cnt and flush_cnt wrap modulo 2^CNT_W.

## Timing
- All control outputs are combinational from the current state and inputs. Pipeline registers act on them at the next clk edge.
- Reset values:
  - State = RUN, counters = 0, bus_error = 0.
  - Outputs during reset: write enables = 1, flushes = 0, mem_wb_flush = 0, pc_sel = 0.
- Load-use costs exactly 1 bubble, because the following cycle sees id_ex_mem_read = 0.
- Penalties: taken branch costs 2 fetch slots; jump costs 1.
- A memory access completing with mem_ready in the same cycle as mem_req never enters MEM_WAIT and costs 0 stall cycles.
- Timeout: bus_error rises at the edge ending the MEM_TIMEOUT-th wait cycle. EXC lasts exactly 1 cycle.
- Simultaneous events:
  - Branch and jump together: the branch wins.
  - Branch and load-use together: the branch wins, with no stall.
  - Freeze dominates all other events.
- Reset asserted mid-MEM_WAIT returns immediately to RUN with the counters cleared.

## Structure
- Shared package `pipeline_ctrl_pkg`: state enum, PC_SEL_SEQ/BRANCH/JUMP/EXC constants, EXC_VECTOR = 32'h8000_0180 (used by the PC mux, not by this block).
- Sub-module `load_use_detect`: purely combinational comparator producing `lu_hazard`.
- FSM, watchdog and counters live in the top module.

## Test plan
- Load-use: id_ex_mem_read = 1, id_ex_rt = 8, if_id_rs = 8 for one cycle -> pc_write = 0, if_id_write = 0, id_ex_flush = 1 for exactly 1 cycle; stall_cnt = 1. Repeat with id_ex_rt = 0 -> no stall.
- Taken branch coincident with jump_id and a load-use hazard -> pc_sel = 1, if_id_flush = 1, id_ex_flush = 1, pc_write = 1; flush_cnt increments by 1.
- mem_req = 1, mem_ready low for 3 cycles -> all write enables 0 and mem_wb_flush = 1 for 3 cycles; RUN resumes on the mem_ready cycle; stall_cnt = 3.
- MEM_TIMEOUT = 4, mem_ready held 0 -> bus_error = 1 after 4 wait cycles; one EXC cycle with pc_sel = 3 and all flushes high; then RUN; bus_error stays set.
- Reset asserted during MEM_WAIT -> outputs return to their reset values asynchronously; state RUN, counters 0, bus_error 0.
- CNT_W = 4, 17 load-use stalls -> stall_cnt = 1 (wrap).
